// File: rtl/fwd_select_unit.sv
// ---------------------------------------------------------------------------
// fwd_select_unit
//   Forwarding control for the EX-stage operand muxes (4:1, select encoding
//   00 = register file, 01 = EX/MEM, 10 = MEM/WB, 11 = WB-retired).
//   Tracks the three instructions ahead of EX, registers the operand selects
//   for the instruction entering EX, supplies the forwarded data words and
//   detects load-use hazards.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   stall_i           pipeline freeze, every register holds
//   flush_i           squash the instruction entering EX
//   ex_valid_i        EX instruction is real
//   ex_reg_write_i    EX instruction writes a register
//   ex_mem_read_i     EX instruction is a load
//   ex_rd_i           EX destination register
//   ex_result_i       EX ALU result (load address for loads)
//   mem_load_data_i   load data returned during MEM
//   id_valid_i        ID instruction is real
//   id_rs_i/id_rt_i   ID source registers
//   fwd_sel_a_o/b_o   registered operand mux selects
//   exmem_data_o      mux input 1
//   memwb_data_o      mux input 2
//   wb_data_o         mux input 3
//   load_use_stall_o  combinational load-use hazard
//   stall_count_o     saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module fwd_select_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [DATA_W-1:0] mem_load_data_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic [1:0]        fwd_sel_a_o,
  output logic [1:0]        fwd_sel_b_o,
  output logic [DATA_W-1:0] exmem_data_o,
  output logic [DATA_W-1:0] memwb_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              load_use_stall_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  // EX/MEM stage
  logic              exmem_valid_q, exmem_we_q, exmem_load_q;
  logic [REG_AW-1:0] exmem_rd_q;
  logic [DATA_W-1:0] exmem_data_q;
  // MEM/WB stage
  logic              memwb_valid_q, memwb_we_q;
  logic [REG_AW-1:0] memwb_rd_q;
  logic [DATA_W-1:0] memwb_data_q, memwb_data_d;
  // WB-retired stage
  logic              wb_valid_q, wb_we_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [1:0]        sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              exmem_valid_d;
  logic              sel_clear;

  // Newest producer wins. The producer in EX now sits in EX/MEM when the
  // consumer executes (01), EX/MEM moves to MEM/WB (10), MEM/WB to WB (11).
  function automatic logic [1:0] pick_src(
    input logic [REG_AW-1:0] src,
    input logic              ex_hit_en,
    input logic [REG_AW-1:0] ex_rd,
    input logic              exmem_hit_en,
    input logic [REG_AW-1:0] exmem_rd,
    input logic              memwb_hit_en,
    input logic [REG_AW-1:0] memwb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (ex_hit_en && (ex_rd == src))
        sel = 2'b01;
      else if (exmem_hit_en && (exmem_rd == src))
        sel = 2'b10;
      else if (memwb_hit_en && (memwb_rd == src))
        sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    load_use_stall_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                       id_valid_i && ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));
  end

  always_comb begin
    exmem_valid_d = ex_valid_i & ~flush_i & ~load_use_stall_o;
    memwb_data_d  = exmem_load_q ? mem_load_data_i : exmem_data_q;
    sel_clear     = flush_i | load_use_stall_o | ~id_valid_i;
    sel_a_d       = 2'b00;
    sel_b_d       = 2'b00;
    if (!sel_clear) begin
      sel_a_d = pick_src(id_rs_i, ex_valid_i & ex_reg_write_i, ex_rd_i,
                         exmem_valid_q & exmem_we_q, exmem_rd_q,
                         memwb_valid_q & memwb_we_q, memwb_rd_q);
      sel_b_d = pick_src(id_rt_i, ex_valid_i & ex_reg_write_i, ex_rd_i,
                         exmem_valid_q & exmem_we_q, exmem_rd_q,
                         memwb_valid_q & memwb_we_q, memwb_rd_q);
    end
    cnt_d = cnt_q;
    if (load_use_stall_o && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_valid_q <= 1'b0;
      exmem_we_q    <= 1'b0;
      exmem_load_q  <= 1'b0;
      exmem_rd_q    <= '0;
      exmem_data_q  <= '0;
      memwb_valid_q <= 1'b0;
      memwb_we_q    <= 1'b0;
      memwb_rd_q    <= '0;
      memwb_data_q  <= '0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      sel_a_q       <= 2'b00;
      sel_b_q       <= 2'b00;
      cnt_q         <= '0;
    end else if (!stall_i) begin
      exmem_valid_q <= exmem_valid_d;
      exmem_we_q    <= ex_reg_write_i;
      exmem_load_q  <= ex_mem_read_i;
      exmem_rd_q    <= ex_rd_i;
      exmem_data_q  <= ex_result_i;
      memwb_valid_q <= exmem_valid_q;
      memwb_we_q    <= exmem_we_q;
      memwb_rd_q    <= exmem_rd_q;
      memwb_data_q  <= memwb_data_d;
      wb_valid_q    <= memwb_valid_q;
      wb_we_q       <= memwb_we_q;
      wb_rd_q       <= memwb_rd_q;
      wb_data_q     <= memwb_data_q;
      sel_a_q       <= sel_a_d;
      sel_b_q       <= sel_b_d;
      cnt_q         <= cnt_d;
    end
  end

  // WB-retired bookkeeping is kept for observability of the stage but no
  // forwarding decision looks past MEM/WB.
  logic unused_wb_state;
  assign unused_wb_state = ^{wb_valid_q, wb_we_q, wb_rd_q};

  assign fwd_sel_a_o   = sel_a_q;
  assign fwd_sel_b_o   = sel_b_q;
  assign exmem_data_o  = exmem_data_q;
  assign memwb_data_o  = memwb_data_q;
  assign wb_data_o     = wb_data_q;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_fwd_select_unit.sv
module tb_fwd_select_unit;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  localparam logic [6:0] M_SA  = 7'd1;
  localparam logic [6:0] M_SB  = 7'd2;
  localparam logic [6:0] M_EX  = 7'd4;
  localparam logic [6:0] M_MW  = 7'd8;
  localparam logic [6:0] M_WB  = 7'd16;
  localparam logic [6:0] M_LUS = 7'd32;
  localparam logic [6:0] M_CNT = 7'd64;
  localparam logic [6:0] M_ALL = 7'd127;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall_i = 1'b0, flush_i = 1'b0;
  logic              ex_valid_i = 1'b0, ex_reg_write_i = 1'b0, ex_mem_read_i = 1'b0;
  logic [REG_AW-1:0] ex_rd_i = '0;
  logic [DATA_W-1:0] ex_result_i = '0, mem_load_data_i = '0;
  logic              id_valid_i = 1'b0;
  logic [REG_AW-1:0] id_rs_i = '0, id_rt_i = '0;
  logic [1:0]        fwd_sel_a_o, fwd_sel_b_o;
  logic [DATA_W-1:0] exmem_data_o, memwb_data_o, wb_data_o;
  logic              load_use_stall_o;
  logic [CNT_W-1:0]  stall_count_o;

  fwd_select_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i), .ex_result_i(ex_result_i),
    .mem_load_data_i(mem_load_data_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .fwd_sel_a_o(fwd_sel_a_o), .fwd_sel_b_o(fwd_sel_b_o),
    .exmem_data_o(exmem_data_o), .memwb_data_o(memwb_data_o), .wb_data_o(wb_data_o),
    .load_use_stall_o(load_use_stall_o), .stall_count_o(stall_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [6:0]  m;
    logic [1:0]  sa, sb;
    logic [31:0] ex, mw, wb;
    logic        lus;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic exv, input logic exw,
                       input logic exm, input logic [4:0] exrd, input logic [31:0] exres,
                       input logic [31:0] ldd, input logic idv, input logic [4:0] rs,
                       input logic [4:0] rt);
    @(negedge clk);
    stall_i = st; flush_i = fl; ex_valid_i = exv; ex_reg_write_i = exw;
    ex_mem_read_i = exm; ex_rd_i = exrd; ex_result_i = exres;
    mem_load_data_i = ldd; id_valid_i = idv; id_rs_i = rs; id_rt_i = rt;
  endtask

  task automatic expect_after(input string tag, input logic [6:0] m, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [31:0] ex, input logic [31:0] mw,
                              input logic [31:0] wb, input logic lus, input logic [3:0] cnt);
    exp_t e;
    e.tag = tag; e.m = m; e.sa = sa; e.sb = sb; e.ex = ex; e.mw = mw; e.wb = wb;
    e.lus = lus; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per clock, compared just after the edge.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.m[0]) chk({mon_e.tag, ".sel_a"}, 32'(fwd_sel_a_o), 32'(mon_e.sa));
      if (mon_e.m[1]) chk({mon_e.tag, ".sel_b"}, 32'(fwd_sel_b_o), 32'(mon_e.sb));
      if (mon_e.m[2]) chk({mon_e.tag, ".exmem"}, exmem_data_o, mon_e.ex);
      if (mon_e.m[3]) chk({mon_e.tag, ".memwb"}, memwb_data_o, mon_e.mw);
      if (mon_e.m[4]) chk({mon_e.tag, ".wb"}, wb_data_o, mon_e.wb);
      if (mon_e.m[5]) chk({mon_e.tag, ".lus"}, 32'(load_use_stall_o), 32'(mon_e.lus));
      if (mon_e.m[6]) chk({mon_e.tag, ".cnt"}, 32'(stall_count_o), 32'(mon_e.cnt));
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".sel_a"}, 32'(fwd_sel_a_o), 32'd0);
    chk({tag, ".sel_b"}, 32'(fwd_sel_b_o), 32'd0);
    chk({tag, ".exmem"}, exmem_data_o, 32'd0);
    chk({tag, ".memwb"}, memwb_data_o, 32'd0);
    chk({tag, ".wb"}, wb_data_o, 32'd0);
    chk({tag, ".cnt"}, 32'(stall_count_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("reset");
    chk("reset.lus", 32'(load_use_stall_o), 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd0);
      expect_after("idle", M_ALL, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    end

    // back-to-back ALU dependency
    drive(0,0, 1,1,0, 5'd5, 32'hAA, 32'h0, 1, 5'd5, 5'd0);
    expect_after("alu_dep", M_SA|M_SB|M_EX|M_LUS|M_CNT, 2'b01, 2'b00, 32'hAA, 0, 0, 1'b0, 4'd0);

    // three writers of r7, consumer sees the newest
    drive(0,0, 1,1,0, 5'd7, 32'd1, 32'h0, 0, 5'd0, 5'd0);
    expect_after("prio_w1", M_SA|M_EX|M_MW, 2'b00, 2'b00, 32'd1, 32'hAA, 0, 1'b0, 4'd0);
    drive(0,0, 1,1,0, 5'd7, 32'd2, 32'h0, 0, 5'd0, 5'd0);
    expect_after("prio_w2", M_EX|M_MW|M_WB, 2'b00, 2'b00, 32'd2, 32'd1, 32'hAA, 1'b0, 4'd0);
    drive(0,0, 1,1,0, 5'd7, 32'd3, 32'h0, 1, 5'd7, 5'd7);
    expect_after("prio_all", M_SA|M_SB|M_EX|M_MW|M_WB, 2'b01, 2'b01, 32'd3, 32'd2, 32'd1, 1'b0, 4'd0);

    // only the oldest writer remains in range
    drive(0,0, 1,1,0, 5'd7, 32'd1, 32'h0, 0, 5'd0, 5'd0);
    expect_after("old_w", M_EX|M_MW|M_WB, 2'b00, 2'b00, 32'd1, 32'd3, 32'd2, 1'b0, 4'd0);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd0);
    expect_after("old_bub", M_EX|M_MW, 2'b00, 2'b00, 32'd0, 32'd1, 0, 1'b0, 4'd0);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd7, 5'd7);
    expect_after("old_use", M_SA|M_SB|M_WB, 2'b11, 2'b11, 0, 0, 32'd1, 1'b0, 4'd0);

    // load-use: lw r9 in EX, ID reads rt=9; the load is bubbled
    drive(0,0, 1,1,1, 5'd9, 32'h100, 32'h0, 1, 5'd0, 5'd9);
    expect_after("lu_stall", M_SA|M_SB|M_EX|M_LUS|M_CNT, 2'b00, 2'b00, 32'h100, 0, 0, 1'b1, 4'd1);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 5'd9);
    expect_after("lu_bubble", M_SB|M_LUS|M_CNT, 2'b00, 2'b00, 0, 0, 0, 1'b0, 4'd1);
    // load that advances, consumer one slot behind takes it from MEM/WB
    drive(0,0, 1,1,1, 5'd9, 32'h100, 32'h0, 1, 5'd1, 5'd2);
    expect_after("lw_pass", M_SA|M_SB|M_EX|M_LUS, 2'b00, 2'b00, 32'h100, 0, 0, 1'b0, 4'd1);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'hDEADBEEF, 1, 5'd0, 5'd9);
    expect_after("lw_fwd", M_SA|M_SB|M_MW|M_CNT, 2'b00, 2'b10, 0, 32'hDEADBEEF, 0, 1'b0, 4'd1);

    // r0 is never forwarded
    drive(0,0, 1,1,0, 5'd0, 32'h55, 32'h0, 1, 5'd0, 5'd0);
    expect_after("r0_ex", M_SA|M_SB|M_EX|M_WB, 2'b00, 2'b00, 32'h55, 0, 32'hDEADBEEF, 1'b0, 4'd1);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 5'd0);
    expect_after("r0_exmem", M_SA|M_MW, 2'b00, 2'b00, 0, 32'h55, 0, 1'b0, 4'd1);

    // flushed producer never forwards from any later stage
    drive(0,1, 1,1,0, 5'd3, 32'h33, 32'h0, 1, 5'd3, 5'd3);
    expect_after("flush", M_SA|M_SB|M_EX, 2'b00, 2'b00, 32'h33, 0, 0, 1'b0, 4'd1);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 5'd3);
    expect_after("flush_exmem", M_SA|M_SB, 2'b00, 2'b00, 0, 0, 0, 1'b0, 4'd1);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 5'd3);
    expect_after("flush_memwb", M_SA|M_SB|M_WB, 2'b00, 2'b00, 0, 0, 32'h33, 1'b0, 4'd1);

    // freeze for four cycles with a load-use and flush pending
    drive(0,0, 1,1,0, 5'd4, 32'h44, 32'h0, 1, 5'd4, 5'd0);
    expect_after("pre_stall", M_ALL, 2'b01, 2'b00, 32'h44, 0, 0, 1'b0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1,1, 1,1,1, 5'd6, 32'h66, 32'h77, 1, 5'd6, 5'd6);
      expect_after("frozen", M_ALL, 2'b01, 2'b00, 32'h44, 0, 0, 1'b1, 4'd1);
    end
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd4, 5'd0);
    expect_after("resume1", M_ALL, 2'b10, 2'b00, 0, 32'h44, 0, 1'b0, 4'd1);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd4, 5'd0);
    expect_after("resume2", M_ALL, 2'b11, 2'b00, 0, 0, 32'h44, 1'b0, 4'd1);

    // counter saturation; first stall also has flush asserted
    for (int i = 0; i < 15; i++) begin
      drive(0, (i == 0), 1,1,1, 5'd8, 32'(i), 32'h0, 1, 5'd8, 5'd1);
      expect_after("sat", M_SA|M_SB|M_EX|M_LUS|M_CNT, 2'b00, 2'b00, 32'(i), 0, 0, 1'b1,
                   (i + 2 > 15) ? 4'd15 : 4'(i + 2));
    end
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd8, 5'd8);
    expect_after("sat_bubble", M_SA|M_SB|M_LUS|M_CNT, 2'b00, 2'b00, 0, 0, 0, 1'b0, 4'd15);

    // asynchronous reset mid-operation
    drive(0,0, 1,1,0, 5'd2, 32'h22, 32'h0, 0, 5'd0, 5'd0);
    expect_after("pre_rst", M_EX|M_CNT, 2'b00, 2'b00, 32'h22, 0, 0, 1'b0, 4'd15);
    drain();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    ex_valid_i = 1'b0; ex_reg_write_i = 1'b0; ex_rd_i = '0; ex_result_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 1, 5'd2, 5'd2);
    expect_after("post_rst", M_ALL, 2'b00, 2'b00, 0, 0, 0, 1'b0, 4'd0);
    drive(0,0, 0,0,0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
